// File: rtl/model_vector_stream_accumulator_pkg.sv
// Shared encodings and constants for the vector series blocks (sqrt, accumulator, ...).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package model_vector_stream_accumulator_pkg;

  // Common three-phase controller encoding shared by the vector series blocks.
  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    INPUT_STATE   = 2'd1,
    ENDER_STATE   = 2'd2
  } vector_state_t;

  // Index/counter constants; users cast them to their own CONTROL_SIZE.
  localparam logic [63:0] ZERO_CONTROL  = 64'd0;
  localparam logic [63:0] ONE_CONTROL   = 64'd1;
  localparam logic [63:0] TWO_CONTROL   = 64'd2;
  localparam logic [63:0] THREE_CONTROL = 64'd3;

  // Data-path constants; users cast them to their own DATA_SIZE.
  localparam logic [63:0] ZERO_DATA  = 64'd0;
  localparam logic [63:0] ONE_DATA   = 64'd1;
  localparam logic [63:0] TWO_DATA   = 64'd2;
  localparam logic [63:0] THREE_DATA = 64'd3;

  // Single-bit flag levels.
  localparam logic FULL  = 1'b1;
  localparam logic EMPTY = 1'b0;

endpackage

// File: rtl/model_scalar_adder_carry.sv
// Unsigned DATA_SIZE-bit adder that also exposes the carry out of the top bit.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module model_scalar_adder_carry #(
  parameter int DATA_SIZE = 64
) (
  input  logic [DATA_SIZE-1:0] a_i,
  input  logic [DATA_SIZE-1:0] b_i,
  output logic [DATA_SIZE-1:0] sum_o,
  output logic                 carry_o
);

  // Widen both operands by one bit so the carry lands in the extra MSB.
  always_comb begin
    {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
  end

endmodule

// File: rtl/model_vector_stream_accumulator.sv
// Sums SIZE_IN strobed elements into one scalar and reports it with a READY pulse and sticky overflow.
// Latency: result registered one edge after the last element is sampled; READY is high for one cycle.
// Backpressure: none; one element per cycle is always accepted, strobes outside INPUT_STATE are dropped.
module model_vector_stream_accumulator
  import model_vector_stream_accumulator_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 OVERFLOW
);

  vector_state_t             state_q, state_d;
  logic [DATA_SIZE-1:0]      size_q, size_d;
  logic [CONTROL_SIZE-1:0]   index_q, index_d;
  logic [DATA_SIZE-1:0]      acc_q, acc_d;
  logic                      ovf_int_q, ovf_int_d;
  logic                      ready_q, ready_d;
  logic [DATA_SIZE-1:0]      data_out_q, data_out_d;
  logic                      overflow_q, overflow_d;

  logic [DATA_SIZE-1:0]      sum_w;
  logic                      carry_w;
  logic                      last_elem_w;
  logic                      size_zero_w;

  model_scalar_adder_carry #(
    .DATA_SIZE(DATA_SIZE)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (DATA_IN),
    .sum_o  (sum_w),
    .carry_o(carry_w)
  );

  // Index compare runs at counter width; the latched size is resized to match.
  assign last_elem_w = (index_q == (CONTROL_SIZE'(size_q) - CONTROL_SIZE'(ONE_CONTROL)));
  assign size_zero_w = (SIZE_IN == DATA_SIZE'(ZERO_DATA));

  // Next-state and datapath updates for the start / collect / report phases.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    index_d    = index_q;
    acc_d      = acc_q;
    ovf_int_d  = ovf_int_q;
    ready_d    = EMPTY;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    case (state_q)
      STARTER_STATE: begin
        // Elements strobed alongside START are deliberately not captured.
        if (START) begin
          size_d    = SIZE_IN;
          index_d   = CONTROL_SIZE'(ZERO_CONTROL);
          acc_d     = DATA_SIZE'(ZERO_DATA);
          ovf_int_d = EMPTY;
          state_d   = size_zero_w ? ENDER_STATE : INPUT_STATE;
        end
      end

      INPUT_STATE: begin
        if (DATA_IN_ENABLE) begin
          acc_d     = sum_w;
          ovf_int_d = ovf_int_q | carry_w;
          if (last_elem_w) begin
            state_d = ENDER_STATE;
          end else begin
            index_d = index_q + CONTROL_SIZE'(ONE_CONTROL);
          end
        end
      end

      ENDER_STATE: begin
        data_out_d = acc_q;
        overflow_d = ovf_int_q;
        ready_d    = FULL;
        state_d    = STARTER_STATE;
      end

      // The unused encoding falls back to idle.
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  // State and output registers with synchronous reset that discards any partial sum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= STARTER_STATE;
      size_q     <= '0;
      index_q    <= '0;
      acc_q      <= '0;
      ovf_int_q  <= 1'b0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      index_q    <= index_d;
      acc_q      <= acc_d;
      ovf_int_q  <= ovf_int_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign READY    = ready_q;
  assign DATA_OUT = data_out_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_model_vector_stream_accumulator.sv
// Bench for the stream accumulator built at 8-bit data width so overflow is easy to reach.
// Latency: expects the result one edge after the last element, READY high for one cycle.
// Backpressure: none; stimulus strobes elements freely, including during ignored phases.
module tb_model_vector_stream_accumulator;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic          START;
  logic          READY;
  logic          DATA_IN_ENABLE;
  logic [DW-1:0] SIZE_IN;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] DATA_OUT;
  logic          OVERFLOW;

  model_vector_stream_accumulator #(
    .DATA_SIZE   (DW),
    .CONTROL_SIZE(64)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .READY         (READY),
    .DATA_IN_ENABLE(DATA_IN_ENABLE),
    .SIZE_IN       (SIZE_IN),
    .DATA_IN       (DATA_IN),
    .DATA_OUT      (DATA_OUT),
    .OVERFLOW      (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // Hand-computed results, one per expected READY pulse, in order.
  logic [DW-1:0] lit_out [8];
  logic          lit_ovf [8];
  int            lit_n = 0;
  int            lit_idx = 0;
  logic          done = 1'b0;

  // Reference model: counts elements and keeps the exact integer total.
  logic          model_ok = 1'b0;
  logic          exp_ready = 1'b0;
  logic [DW-1:0] exp_out = '0;
  logic          exp_ovf = 1'b0;
  logic          collecting = 1'b0;
  logic          report = 1'b0;
  int            remaining = 0;
  int            total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Model reacts to the inputs seen at each rising edge.
  always @(posedge CLK) begin
    if (RST) begin
      model_ok   = 1'b1;
      exp_ready  = 1'b0;
      exp_out    = '0;
      exp_ovf    = 1'b0;
      collecting = 1'b0;
      report     = 1'b0;
      remaining  = 0;
      total      = 0;
    end else begin
      exp_ready = 1'b0;
      if (report) begin
        exp_ready = 1'b1;
        exp_out   = DW'(total % 256);
        exp_ovf   = (total > 255);
        report    = 1'b0;
      end else if (collecting) begin
        if (DATA_IN_ENABLE) begin
          total     = total + int'(DATA_IN);
          remaining = remaining - 1;
          if (remaining == 0) begin
            collecting = 1'b0;
            report     = 1'b1;
          end
        end
      end else if (START) begin
        total      = 0;
        remaining  = int'(SIZE_IN);
        collecting = (SIZE_IN != 0);
        report     = (SIZE_IN == 0);
      end
    end
  end

  // Single compare point, away from the active edge.
  always @(negedge CLK) begin
    if (model_ok) begin
      chk("ready", 64'(READY), 64'(exp_ready));
      chk("data_out", 64'(DATA_OUT), 64'(exp_out));
      chk("overflow", 64'(OVERFLOW), 64'(exp_ovf));
      if (READY === 1'b1 && lit_idx < lit_n) begin
        chk("lit_data_out", 64'(DATA_OUT), 64'(lit_out[lit_idx]));
        chk("lit_overflow", 64'(OVERFLOW), 64'(lit_ovf[lit_idx]));
        lit_idx++;
      end
    end
    if (done) begin
      chk("ready_pulse_count", 64'(lit_idx), 64'(lit_n));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  end

  task automatic step(input logic rst, input logic st, input logic [DW-1:0] sz,
                      input logic en, input logic [DW-1:0] d);
    RST            = rst;
    START          = st;
    SIZE_IN        = sz;
    DATA_IN_ENABLE = en;
    DATA_IN        = d;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    lit_out[0] = 8'd10; lit_ovf[0] = 1'b0;  // 1+2+3+4
    lit_out[1] = 8'd21; lit_ovf[1] = 1'b0;  // 5+7+9, gapped
    lit_out[2] = 8'd44; lit_ovf[2] = 1'b1;  // 200+100 = 300 - 256
    lit_out[3] = 8'd2;  lit_ovf[3] = 1'b0;  // 1+1, overflow cleared
    lit_out[4] = 8'd0;  lit_ovf[4] = 1'b0;  // empty vector
    lit_out[5] = 8'd9;  lit_ovf[5] = 1'b0;  // sqrt(4)+sqrt(9)+sqrt(16)
    lit_out[6] = 8'd11; lit_ovf[6] = 1'b0;  // 5+6, started in READY cycle
    lit_out[7] = 8'd4;  lit_ovf[7] = 1'b0;  // 1+1+1+1 after reset abort
    lit_n = 8;

    RST = 1'b1; START = 1'b0; SIZE_IN = '0; DATA_IN_ENABLE = 1'b0; DATA_IN = '0;
    @(negedge CLK);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);

    // Basic: SIZE_IN changes after START must not matter.
    step(1'b0, 1'b1, 8'd4, 1'b0, '0);
    step(1'b0, 1'b0, 8'd9, 1'b1, 8'd1);
    step(1'b0, 1'b0, 8'd1, 1'b1, 8'd2);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd3);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd4);
    idle(3);

    // Gapped: element with START dropped, START mid-vector ignored.
    step(1'b0, 1'b1, 8'd3, 1'b1, 8'd50);
    idle(1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd5);
    idle(2);
    step(1'b0, 1'b1, 8'd1, 1'b1, 8'd7);
    idle(3);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd9);
    idle(2);

    // Overflow, then a clean vector.
    step(1'b0, 1'b1, 8'd2, 1'b0, '0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd200);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd100);
    idle(2);
    step(1'b0, 1'b1, 8'd2, 1'b0, '0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd1);
    idle(2);

    // Empty vector with strobes during the report window.
    step(1'b0, 1'b1, 8'd0, 1'b0, '0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd77);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd88);
    idle(2);

    // Chained with upstream sqrt outputs 2,3,4; restart in the READY cycle.
    step(1'b0, 1'b1, 8'd3, 1'b0, '0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd2);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd3);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd4);
    idle(1);
    step(1'b0, 1'b1, 8'd2, 1'b0, '0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd5);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd6);
    idle(2);

    // Reset mid-vector aborts; a fresh vector then completes.
    step(1'b0, 1'b1, 8'd4, 1'b0, '0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd2);
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd3);
    idle(3);
    step(1'b0, 1'b1, 8'd4, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 8'd1);
    idle(3);

    done = 1'b1;
  end

endmodule

// File: doc/model_vector_stream_accumulator.md
Name: model_vector_stream_accumulator

Overview:
Downstream neighbour of the vector sqrt stage. It consumes that stage's element stream (DATA_OUT / DATA_OUT_ENABLE) and sums SIZE_IN elements into one scalar. It emits the sum with a one-cycle READY pulse and a sticky overflow flag. Typical use: the reduction step after an element-wise vector operation in the NTM addressing path.

Parameters:
DATA_SIZE, 64, width of elements, SIZE_IN and the sum
CONTROL_SIZE, 64, width of the internal element index counter

Ports:
CLK  in  1  single clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse that opens a new vector; sampled only in STARTER_STATE
READY  out  1  one-cycle pulse; DATA_OUT and OVERFLOW are valid while high
DATA_IN_ENABLE  in  1  element strobe (wired to upstream DATA_OUT_ENABLE)
SIZE_IN  in  DATA_SIZE  number of elements; latched on accepted START
DATA_IN  in  DATA_SIZE  element value, unsigned
DATA_OUT  out  DATA_SIZE  accumulated sum modulo 2^DATA_SIZE
OVERFLOW  out  1  set if any addition produced a carry out of DATA_SIZE bits

Behaviour:
- Interface (already decided): one clock, CLK. Reset RST is synchronous and active-high.
- Reset (RST=1 at a rising edge):
  - Outputs: READY=0, DATA_OUT=0, OVERFLOW=0.
  - Internal: state=STARTER_STATE, index=0, accumulator=0, size register=0.
  - Reset mid-vector aborts with no READY pulse; partial sum is discarded.
- FSM (2-bit): STARTER_STATE=0, INPUT_STATE=1, ENDER_STATE=2. Encoding 3 returns to STARTER_STATE on the next edge.
- STARTER_STATE:
  - READY<=0.
  - On START=1: size_reg<=SIZE_IN, index<=0, accumulator<=0, overflow_int<=0.
  - Next state is ENDER_STATE if SIZE_IN==0, otherwise INPUT_STATE.
  - DATA_IN_ENABLE is ignored in this state. An element strobed in the same cycle as START is dropped.
- INPUT_STATE, on each DATA_IN_ENABLE=1:
  - {carry, accumulator} <= accumulator + DATA_IN, computed at DATA_SIZE+1 bits.
  - overflow_int <= overflow_int | carry.
  - If index==size_reg-1, go to ENDER_STATE; else index<=index+1.
  - Back-to-back strobes (one per cycle) are accepted with no stall.
  - START is ignored while in INPUT_STATE.
- ENDER_STATE (one cycle):
  - DATA_OUT<=accumulator, OVERFLOW<=overflow_int, READY<=1.
  - Next state STARTER_STATE. DATA_IN_ENABLE and START are ignored.
- Latency: the last element is sampled at edge k. READY, DATA_OUT and OVERFLOW update at edge k+1. READY drops at edge k+2.
- DATA_OUT and OVERFLOW hold their value until the next ENDER_STATE.
- Restart: a new START is accepted in the cycle READY is high, because the FSM is already in STARTER_STATE.
- SIZE_IN=0: READY pulses at the second edge after START with DATA_OUT=0 and OVERFLOW=0.
- SIZE_IN changes after START have no effect; the size is latched.
- Index comparison is done at CONTROL_SIZE width, with size_reg zero-extended or truncated to CONTROL_SIZE.

Decomposition:
- Shared package holds:
  - the state encodings (STARTER/INPUT/ENDER), also used by the vector sqrt and other vector series blocks;
  - ZERO/ONE/TWO/THREE_CONTROL and _DATA constants;
  - FULL/EMPTY.
- Optional sub-module model_scalar_adder_carry: combinational DATA_SIZE+1-bit adder returning sum and carry. It is natural and reusable, but inlining it is acceptable.
- No memories; the block is register-only.

Test Plan:
- Basic: SIZE_IN=4, elements 1,2,3,4 on consecutive cycles -> single READY pulse one edge after the 4th element, DATA_OUT=10, OVERFLOW=0.
- Gapped stream: SIZE_IN=3, elements 5,7,9 with 0-3 idle cycles between strobes -> DATA_OUT=21. No READY before the third element.
- Overflow: DATA_SIZE=8 build, SIZE_IN=2, elements 200,100 -> DATA_OUT=44, OVERFLOW=1. The next vector (1,1) gives DATA_OUT=2, OVERFLOW=0.
- Empty vector: SIZE_IN=0, START -> READY at the 2nd edge after START, DATA_OUT=0. DATA_IN_ENABLE pulses during that window change nothing.
- Chained with upstream sqrt: vector sqrt fed 4,9,16 (SIZE_IN=3); this block started one cycle earlier with SIZE_IN=3 -> DATA_OUT=9. Issuing START again in the READY cycle begins the next vector without loss.
- Reset mid-vector: SIZE_IN=4, two elements in, RST=1 for one cycle -> READY, DATA_OUT and OVERFLOW are 0 and no READY pulse occurs. A fresh START with 1,1,1,1 gives DATA_OUT=4.
